// File: rtl/hplvds_pkg.sv
// HPLVDS transmit link controller shared types and constants.
// State encoding, framing bytes and the preamble pattern helper.
package hplvds_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SETTLE,
    ST_IDLE,
    ST_PRE,
    ST_SYNC,
    ST_DATA,
    ST_TAIL,
    ST_GAP
  } state_e;

  localparam logic [7:0] SYNC_BYTE  = 8'hBC;
  localparam logic [7:0] EOF_BYTE   = 8'hFD;
  localparam logic [7:0] ABORT_BYTE = 8'hF7;

  localparam logic PRE_START_BIT = 1'b1;

  // Eight alternating bits, LSB first, beginning with the start bit.
  // Eight is even, so reloading keeps the alternation unbroken.
  function automatic logic [7:0] pre_word(input logic start);
    return start ? 8'h55 : 8'hAA;
  endfunction

endpackage

// File: rtl/hplvds_tx_shifter.sv
// HPLVDS byte serializer: LSB-first shift register with bit counter.
// Bit 0 of the register drives the pad data line directly.
module hplvds_tx_shifter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_shift,
  output logic       o_bit,
  output logic       o_bit7,
  output logic       o_last
);

  logic [7:0] r_sr;
  logic [2:0] r_cnt;
  logic       r_last;

  // Load a byte, or shift one bit out per cycle; counter wraps 7->0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_sr   <= i_data;
      r_cnt  <= '0;
      r_last <= i_last;
    end else if (i_shift) begin
      r_sr  <= {1'b0, r_sr[7:1]};
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_bit  = r_sr[0];
  assign o_bit7 = (r_cnt == 3'd7);
  assign o_last = r_last;

endmodule

// File: rtl/hplvds_tx_link_ctrl.sv
// HPLVDS transmit link controller: pad power sequencing and framing.
// Preamble, SYNC, payload, EOF/ABORT, then an enforced idle gap.
module hplvds_tx_link_ctrl
  import hplvds_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int PREAMBLE_LEN  = 8,
  parameter int GAP_CYCLES    = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       ENABLE_I,
  input  logic       POL_I,
  input  logic [3:0] BIAS_I,
  input  logic [3:0] VCM_I,
  input  logic [7:0] DATA_I,
  input  logic       VALID_I,
  input  logic       LAST_I,
  output logic       READY_O,
  output logic       TX_EN_O,
  output logic       TX_VCM_EN_O,
  output logic       TX_EI_O,
  output logic       TX_POL_O,
  output logic [3:0] TX_BIAS_O,
  output logic [3:0] TX_VCM_O,
  output logic       DO_O,
  output logic       LINK_UP_O,
  output logic       BUSY_O,
  output logic       UNDERRUN_O
);

  localparam int TM0 = (SETTLE_CYCLES > GAP_CYCLES) ?
                       SETTLE_CYCLES : GAP_CYCLES;
  localparam int TMAX = (TM0 > PREAMBLE_LEN) ? TM0 : PREAMBLE_LEN;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] PRE_LAST = TW'(PREAMBLE_LEN - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  state_e        r_state;
  state_e        w_state_n;
  logic [TW-1:0] r_tmr;

  logic          r_tx_en;
  logic          r_ei;
  logic          r_link_up;
  logic          r_busy;
  logic          r_unr;
  logic          r_pol;
  logic [3:0]    r_bias;
  logic [3:0]    r_vcm;

  logic          w_load;
  logic [7:0]    w_ld_data;
  logic          w_ld_last;
  logic          w_shift;
  logic          w_clr;
  logic          w_tmr_clr;
  logic          w_tmr_inc;
  logic          w_unr;
  logic          w_ready;
  logic          w_bit;
  logic          w_bit7;
  logic          w_last;

  hplvds_tx_shifter u_shifter (
    .i_clk   (CLK_I),
    .i_rst   (RST_I),
    .i_clr   (w_clr),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_last  (w_ld_last),
    .i_shift (w_shift),
    .o_bit   (w_bit),
    .o_bit7  (w_bit7),
    .o_last  (w_last)
  );

  assign w_ready = ((r_state == ST_SYNC) || (r_state == ST_DATA))
                 && w_bit7 && !w_last;

  // Next state, shifter control and timer control.
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_ld_data = 8'h00;
    w_ld_last = 1'b0;
    w_shift   = 1'b0;
    w_clr     = 1'b0;
    w_tmr_clr = 1'b0;
    w_tmr_inc = 1'b0;
    w_unr     = 1'b0;
    if (!ENABLE_I) begin
      w_state_n = ST_OFF;
      w_clr     = 1'b1;
      w_tmr_clr = 1'b1;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          w_state_n = ST_SETTLE;
          w_tmr_clr = 1'b1;
        end
        ST_SETTLE: begin
          if (r_tmr == SET_LAST) w_state_n = ST_IDLE;
          else w_tmr_inc = 1'b1;
        end
        ST_IDLE: begin
          if (VALID_I) begin
            w_state_n = ST_PRE;
            w_load    = 1'b1;
            w_ld_data = pre_word(PRE_START_BIT);
            w_tmr_clr = 1'b1;
          end
        end
        ST_PRE: begin
          if (r_tmr == PRE_LAST) begin
            w_state_n = ST_SYNC;
            w_load    = 1'b1;
            w_ld_data = SYNC_BYTE;
          end else begin
            w_tmr_inc = 1'b1;
            if (w_bit7) begin
              w_load    = 1'b1;
              w_ld_data = pre_word(PRE_START_BIT);
            end else begin
              w_shift = 1'b1;
            end
          end
        end
        ST_SYNC, ST_DATA: begin
          if (!w_bit7) begin
            w_shift = 1'b1;
          end else if (w_last) begin
            w_state_n = ST_TAIL;
            w_load    = 1'b1;
            w_ld_data = EOF_BYTE;
          end else if (VALID_I) begin
            w_state_n = ST_DATA;
            w_load    = 1'b1;
            w_ld_data = DATA_I;
            w_ld_last = LAST_I;
          end else begin
            w_state_n = ST_TAIL;
            w_load    = 1'b1;
            w_ld_data = ABORT_BYTE;
            w_unr     = 1'b1;
          end
        end
        ST_TAIL: begin
          if (w_bit7) begin
            w_state_n = ST_GAP;
            w_clr     = 1'b1;
            w_tmr_clr = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
        ST_GAP: begin
          if (r_tmr == GAP_LAST) w_state_n = ST_IDLE;
          else w_tmr_inc = 1'b1;
        end
        default: begin
          w_state_n = ST_OFF;
          w_clr     = 1'b1;
        end
      endcase
    end
  end

  // State, saturating timer and registered pad/status outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state   <= ST_OFF;
      r_tmr     <= '0;
      r_tx_en   <= 1'b0;
      r_ei      <= 1'b1;
      r_link_up <= 1'b0;
      r_busy    <= 1'b0;
      r_unr     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_tmr_clr) r_tmr <= '0;
      else if (w_tmr_inc && (r_tmr != '1))
        r_tmr <= r_tmr + TW'(1);
      r_tx_en   <= (w_state_n != ST_OFF);
      r_ei      <= !(w_state_n inside
                     {ST_PRE, ST_SYNC, ST_DATA, ST_TAIL});
      r_link_up <= w_state_n inside
                   {ST_IDLE, ST_PRE, ST_SYNC,
                    ST_DATA, ST_TAIL, ST_GAP};
      r_busy    <= w_state_n inside
                   {ST_PRE, ST_SYNC, ST_DATA, ST_TAIL, ST_GAP};
      r_unr     <= w_unr;
    end
  end

  // Pad config tracks its inputs only while the pad is off.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_pol  <= 1'b0;
      r_bias <= '0;
      r_vcm  <= '0;
    end else if (r_state == ST_OFF) begin
      r_pol  <= POL_I;
      r_bias <= BIAS_I;
      r_vcm  <= VCM_I;
    end
  end

  assign READY_O     = w_ready;
  assign TX_EN_O     = r_tx_en;
  assign TX_VCM_EN_O = r_tx_en;
  assign TX_EI_O     = r_ei;
  assign TX_POL_O    = r_pol;
  assign TX_BIAS_O   = r_bias;
  assign TX_VCM_O    = r_vcm;
  assign DO_O        = w_bit;
  assign LINK_UP_O   = r_link_up;
  assign BUSY_O      = r_busy;
  assign UNDERRUN_O  = r_unr;

endmodule

// File: tb/tb_hplvds_tx_link_ctrl.sv
// Testbench for hplvds_tx_link_ctrl.
// Frames are checked against a bit-stream model built from framing rules.
module tb_hplvds_tx_link_ctrl;

  localparam int SET = 64;
  localparam int PL  = 8;
  localparam int GAP = 16;

  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic       ENABLE_I;
  logic       POL_I;
  logic [3:0] BIAS_I;
  logic [3:0] VCM_I;
  logic [7:0] DATA_I;
  logic       VALID_I;
  logic       LAST_I;
  logic       READY_O;
  logic       TX_EN_O;
  logic       TX_VCM_EN_O;
  logic       TX_EI_O;
  logic       TX_POL_O;
  logic [3:0] TX_BIAS_O;
  logic [3:0] TX_VCM_O;
  logic       DO_O;
  logic       LINK_UP_O;
  logic       BUSY_O;
  logic       UNDERRUN_O;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] frm[$];
  logic       cfg_pol;
  logic [3:0] cfg_bias;
  logic [3:0] cfg_vcm;

  always #5 CLK_I = ~CLK_I;

  hplvds_tx_link_ctrl #(
    .SETTLE_CYCLES (SET),
    .PREAMBLE_LEN  (PL),
    .GAP_CYCLES    (GAP)
  ) dut (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .ENABLE_I    (ENABLE_I),
    .POL_I       (POL_I),
    .BIAS_I      (BIAS_I),
    .VCM_I       (VCM_I),
    .DATA_I      (DATA_I),
    .VALID_I     (VALID_I),
    .LAST_I      (LAST_I),
    .READY_O     (READY_O),
    .TX_EN_O     (TX_EN_O),
    .TX_VCM_EN_O (TX_VCM_EN_O),
    .TX_EI_O     (TX_EI_O),
    .TX_POL_O    (TX_POL_O),
    .TX_BIAS_O   (TX_BIAS_O),
    .TX_VCM_O    (TX_VCM_O),
    .DO_O        (DO_O),
    .LINK_UP_O   (LINK_UP_O),
    .BUSY_O      (BUSY_O),
    .UNDERRUN_O  (UNDERRUN_O)
  );

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic test_reset();
    RST_I = 1'b1; ENABLE_I = 1'b1; POL_I = 1'b1;
    BIAS_I = 4'hF; VCM_I = 4'hF; DATA_I = 8'hFF;
    VALID_I = 1'b1; LAST_I = 1'b1;
    repeat (3) step();
    n_run++;
    if ({TX_EN_O, TX_VCM_EN_O, TX_EI_O, DO_O} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_pad got %b want 0010",
               {TX_EN_O, TX_VCM_EN_O, TX_EI_O, DO_O});
    end
    n_run++;
    if ({TX_POL_O, TX_BIAS_O, TX_VCM_O} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_cfg got %h want 000",
               {TX_POL_O, TX_BIAS_O, TX_VCM_O});
    end
    n_run++;
    if ({READY_O, LINK_UP_O, BUSY_O, UNDERRUN_O} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status got %b want 0000",
               {READY_O, LINK_UP_O, BUSY_O, UNDERRUN_O});
    end
    RST_I = 1'b0; ENABLE_I = 1'b0; VALID_I = 1'b0; LAST_I = 1'b0;
    step();
    n_run++;
    if ({TX_EN_O, LINK_UP_O} !== 2'b00) begin
      n_fail++;
      $display("FAIL off_hold got %b want 00", {TX_EN_O, LINK_UP_O});
    end
  endtask

  task automatic test_settle(input string nm);
    int  k;
    bit  ei_ok;
    cfg_pol  = 1'($urandom);
    cfg_bias = 4'($urandom_range(1, 15));
    cfg_vcm  = 4'($urandom_range(1, 15));
    POL_I = cfg_pol; BIAS_I = cfg_bias; VCM_I = cfg_vcm;
    step();
    ENABLE_I = 1'b1;
    step();
    n_run++;
    if ({TX_EN_O, TX_VCM_EN_O, TX_EI_O} !== 3'b111) begin
      n_fail++;
      $display("FAIL %s_en got %b want 111", nm,
               {TX_EN_O, TX_VCM_EN_O, TX_EI_O});
    end
    POL_I = ~cfg_pol; BIAS_I = ~cfg_bias; VCM_I = ~cfg_vcm;
    k = 0; ei_ok = 1'b1;
    while (!LINK_UP_O && k < 200) begin
      if (!TX_EI_O) ei_ok = 1'b0;
      step();
      k++;
    end
    n_run++;
    if (k != SET) begin
      n_fail++;
      $display("FAIL %s_time got %0d want %0d", nm, k, SET);
    end
    n_run++;
    if (!ei_ok || TX_EI_O !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ei got %b want 1", nm, ei_ok & TX_EI_O);
    end
    n_run++;
    if ({TX_POL_O, TX_BIAS_O, TX_VCM_O} !==
        {cfg_pol, cfg_bias, cfg_vcm}) begin
      n_fail++;
      $display("FAIL %s_cfg got %h want %h", nm,
               {TX_POL_O, TX_BIAS_O, TX_VCM_O},
               {cfg_pol, cfg_bias, cfg_vcm});
    end
  endtask

  task automatic run_frame(input string nm, input int drop_at);
    logic       exp[$];
    logic       got[$];
    int         rdy[$];
    logic [7:0] b;
    int         sent, idx, cyc, unr, gap, bad, want;
    bit         acc, pv, pr, ei_seen, done, is_unr;
    is_unr = (drop_at >= 0);
    sent = is_unr ? drop_at : frm.size();
    for (int i = 0; i < PL; i++) exp.push_back((i % 2) == 0);
    b = 8'hBC;
    for (int i = 0; i < 8; i++) exp.push_back(b[i]);
    for (int j = 0; j < sent; j++) begin
      b = frm[j];
      for (int i = 0; i < 8; i++) exp.push_back(b[i]);
    end
    b = is_unr ? 8'hF7 : 8'hFD;
    for (int i = 0; i < 8; i++) exp.push_back(b[i]);
    idx = 0; cyc = 0; unr = 0; gap = 0;
    ei_seen = 1'b0; done = 1'b0;
    VALID_I = 1'b1; DATA_I = frm[0]; LAST_I = (frm.size() == 1);
    pv = 1'b1; pr = READY_O;
    while (!done && cyc < 1000) begin
      step();
      cyc++;
      acc = pv & pr;
      if (acc) idx++;
      if (!TX_EI_O) begin
        got.push_back(DO_O);
        ei_seen = 1'b1;
      end else if (ei_seen && BUSY_O) begin
        gap++;
      end
      if (READY_O) rdy.push_back(cyc);
      if (UNDERRUN_O) unr++;
      if (ei_seen && !BUSY_O) done = 1'b1;
      if (idx < frm.size() && idx != drop_at) begin
        VALID_I = 1'b1;
        DATA_I = frm[idx];
        LAST_I = (idx == frm.size() - 1);
      end else begin
        VALID_I = 1'b0;
        LAST_I = 1'b0;
      end
      pv = VALID_I; pr = READY_O;
    end
    n_run++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout got busy=%b want frame end", nm, BUSY_O);
    end
    n_run++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL %s_len got %0d want %0d", nm,
               got.size(), exp.size());
    end
    bad = -1;
    for (int i = 0; i < exp.size(); i++) begin
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad = i;
        break;
      end
    end
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_bits got mismatch at bit %0d want %b",
               nm, bad, exp[bad]);
    end
    want = sent + (is_unr ? 1 : 0);
    n_run++;
    if (rdy.size() != want) begin
      n_fail++;
      $display("FAIL %s_ready_cnt got %0d want %0d", nm,
               rdy.size(), want);
    end
    n_run++;
    if (rdy.size() == 0 || rdy[0] != PL + 8) begin
      n_fail++;
      $display("FAIL %s_latency got %0d want %0d", nm,
               (rdy.size() == 0) ? -1 : rdy[0], PL + 8);
    end
    bad = 0;
    for (int i = 1; i < rdy.size(); i++)
      if (rdy[i] - rdy[i-1] != 8) bad = rdy[i] - rdy[i-1];
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_ready_gap got %0d want 8", nm, bad);
    end
    n_run++;
    if (unr != (is_unr ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_underrun got %0d want %0d", nm,
               unr, is_unr ? 1 : 0);
    end
    n_run++;
    if (gap != GAP) begin
      n_fail++;
      $display("FAIL %s_gap got %0d want %0d", nm, gap, GAP);
    end
  endtask

  task automatic test_single();
    frm = {8'hA5};
    run_frame("single", -1);
  endtask

  task automatic test_back_to_back();
    frm = {8'h01, 8'h02, 8'h03};
    run_frame("b2b", -1);
  endtask

  task automatic test_underrun();
    frm = {8'h5A, 8'hC3};
    run_frame("underrun", 1);
  endtask

  task automatic test_random();
    int n, drop;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 5);
      frm = {};
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      drop = -1;
      if (n > 1 && $urandom_range(0, 2) == 0)
        drop = $urandom_range(1, n - 1);
      run_frame($sformatf("rand%0d", f), drop);
    end
  endtask

  task automatic test_disable();
    int k;
    VALID_I = 1'b1; DATA_I = 8'($urandom); LAST_I = 1'b0;
    k = 0;
    while (!READY_O && k < 100) begin
      step();
      k++;
    end
    n_run++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL dis_ready got timeout want ready");
    end
    step();
    DATA_I = 8'($urandom);
    repeat (3) step();
    ENABLE_I = 1'b0;
    step();
    VALID_I = 1'b0;
    n_run++;
    if ({TX_EN_O, TX_VCM_EN_O, BUSY_O, READY_O,
         TX_EI_O, DO_O, LINK_UP_O, UNDERRUN_O} !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL dis_off got %b want 00001000",
               {TX_EN_O, TX_VCM_EN_O, BUSY_O, READY_O,
                TX_EI_O, DO_O, LINK_UP_O, UNDERRUN_O});
    end
    test_settle("resettle");
  endtask

  task automatic test_gap_hold();
    int  k, phase, ei_hi, busy_hi;
    bit  frozen;
    VALID_I = 1'b1; DATA_I = 8'h3C; LAST_I = 1'b1;
    POL_I = ~cfg_pol; BIAS_I = ~cfg_bias; VCM_I = ~cfg_vcm;
    frozen = 1'b1; k = 0; phase = 0; ei_hi = 0; busy_hi = 0;
    while (phase < 3 && k < 500) begin
      step();
      k++;
      if ({TX_POL_O, TX_BIAS_O, TX_VCM_O} !==
          {cfg_pol, cfg_bias, cfg_vcm}) frozen = 1'b0;
      case (phase)
        0: if (!TX_EI_O) phase = 1;
        1: if (TX_EI_O) begin
             phase = 2;
             ei_hi = 1;
             busy_hi = BUSY_O ? 1 : 0;
           end
        default: if (TX_EI_O) begin
             ei_hi++;
             if (BUSY_O) busy_hi++;
           end else begin
             phase = 3;
           end
      endcase
      POL_I = 1'($urandom);
      BIAS_I = 4'($urandom);
      VCM_I = 4'($urandom);
    end
    n_run++;
    if (phase != 3) begin
      n_fail++;
      $display("FAIL gap_timeout got phase %0d want 3", phase);
    end
    n_run++;
    if (ei_hi != GAP + 1) begin
      n_fail++;
      $display("FAIL gap_idle got %0d want %0d", ei_hi, GAP + 1);
    end
    n_run++;
    if (busy_hi != GAP) begin
      n_fail++;
      $display("FAIL gap_busy got %0d want %0d", busy_hi, GAP);
    end
    n_run++;
    if (!frozen) begin
      n_fail++;
      $display("FAIL cfg_frozen got changed want %h",
               {cfg_pol, cfg_bias, cfg_vcm});
    end
    POL_I = ~cfg_pol; BIAS_I = ~cfg_bias; VCM_I = ~cfg_vcm;
    ENABLE_I = 1'b0; VALID_I = 1'b0; LAST_I = 1'b0;
    step();
    n_run++;
    if ({TX_POL_O, TX_BIAS_O, TX_VCM_O} !==
        {cfg_pol, cfg_bias, cfg_vcm}) begin
      n_fail++;
      $display("FAIL cfg_keep got %h want %h",
               {TX_POL_O, TX_BIAS_O, TX_VCM_O},
               {cfg_pol, cfg_bias, cfg_vcm});
    end
    step();
    n_run++;
    if ({TX_POL_O, TX_BIAS_O, TX_VCM_O} !==
        {~cfg_pol, ~cfg_bias, ~cfg_vcm}) begin
      n_fail++;
      $display("FAIL cfg_capture got %h want %h",
               {TX_POL_O, TX_BIAS_O, TX_VCM_O},
               {~cfg_pol, ~cfg_bias, ~cfg_vcm});
    end
  endtask

  initial begin
    test_reset();
    test_settle("settle");
    test_single();
    test_back_to_back();
    test_underrun();
    test_random();
    test_disable();
    test_gap_hold();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hplvds_tx_link_ctrl.md
Name: hplvds_tx_link_ctrl

Overview:
- Digital transmit-side link controller for the HPLVDS pad.
- Sequences pad power-up (TX enable, VCM enable, settle time) and holds electrical idle between frames.
- Serializes byte frames from a valid/ready source, LSB-first, one bit per clock, onto the pad data input.
- Each frame is sent as preamble, then SYNC byte, then payload, then EOF (or ABORT) byte, then an enforced idle gap.

Parameters:
- SETTLE_CYCLES, 64: cycles after pad enable before the link is up (min 1).
- PREAMBLE_LEN, 8: alternating preamble bits, first bit 1 (min 2).
- GAP_CYCLES, 16: minimum electrical-idle cycles after a frame (min 1).

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  synchronous active-high reset
- ENABLE_I  in  1  link enable
- POL_I  in  1  TX polarity config
- BIAS_I  in  4  TX bias config
- VCM_I  in  4  TX common-mode config
- DATA_I  in  8  payload byte
- VALID_I  in  1  byte valid
- LAST_I  in  1  byte is last of frame (qualified by VALID_I)
- READY_O  out  1  byte accepted when VALID_I & READY_O
- TX_EN_O  out  1  to pad TX_EN_I
- TX_VCM_EN_O  out  1  to pad TX_VCM_EN_I
- TX_EI_O  out  1  to pad TX_EI_I
- TX_POL_O  out  1  to pad TX_POL_I
- TX_BIAS_O  out  4  to pad TX_BIAS_I
- TX_VCM_O  out  4  to pad TX_VCM_I
- DO_O  out  1  to pad DO_I
- LINK_UP_O  out  1  settle complete, link usable
- BUSY_O  out  1  frame or gap in progress
- UNDERRUN_O  out  1  one-cycle pulse on underrun

Behaviour:
- Clocking and reset: one clock, CLK_I. RST_I is synchronous and active-high.
- Reset values:
  - state OFF
  - TX_EN_O=0, TX_VCM_EN_O=0, TX_EI_O=1, DO_O=0
  - TX_POL_O=0, TX_BIAS_O=0, TX_VCM_O=0
  - READY_O=0, LINK_UP_O=0, BUSY_O=0, UNDERRUN_O=0
- Register rules: all outputs are registered except READY_O, which is decoded combinationally from state and bit counter.
- Config capture: POL_I, BIAS_I and VCM_I are registered into TX_POL_O, TX_BIAS_O and TX_VCM_O every cycle in OFF only. They are frozen in all other states.
- States:
  - OFF: pad disabled. Goes to SETTLE when ENABLE_I=1.
  - SETTLE: TX_EN_O=TX_VCM_EN_O=1, TX_EI_O=1. Counts SETTLE_CYCLES, then goes to IDLE.
  - IDLE: LINK_UP_O=1, TX_EI_O=1, DO_O=0. If VALID_I=1 at cycle t, goes to PREAMBLE; the first preamble bit appears on DO_O at t+1 and TX_EI_O=0 from t+1.
  - PREAMBLE: PREAMBLE_LEN bits 1,0,1,0,...
  - SYNC: SYNC_BYTE, 8 bits LSB-first.
  - DATA: shifts the loaded byte out LSB-first.
  - TAIL: sends EOF_BYTE or ABORT_BYTE, 8 bits.
  - GAP: TX_EI_O=1 for GAP_CYCLES, then IDLE. VALID_I is ignored during GAP.
- READY_O: asserted only in the cycle carrying bit 7 of SYNC or bit 7 of a DATA byte, and only if the current byte was not flagged LAST.
- Byte load: on accept, the byte is loaded and its bit 0 is on DO_O the next cycle. Back-to-back bytes therefore have no gap bits.
- First-byte latency: VALID_I seen in IDLE at t gives READY_O at t+PREAMBLE_LEN+8 and the first payload bit at t+PREAMBLE_LEN+9.
- Frame end: an accepted byte with LAST_I=1 is sent, then TAIL sends EOF_BYTE.
- Underrun: READY_O=1 with VALID_I=0 leads to TAIL with ABORT_BYTE and a UNDERRUN_O pulse in the following cycle.
- BUSY_O: 1 in PREAMBLE, SYNC, DATA, TAIL and GAP.
- ENABLE_I=0 in any state other than OFF: next state is OFF with reset output values (config registers keep their values). The frame is discarded, with no flag and no tail.
- RST_I mid-frame: same as reset; the counter and shifter are cleared.
- Counters: the bit counter is 3 bits and wraps 7 to 0. The settle and gap counters are clog2-sized and saturate, never wrapping.

Decomposition:
- Package hplvds_pkg holds:
  - the state enum
  - SYNC_BYTE=8'hBC, EOF_BYTE=8'hFD, ABORT_BYTE=8'hF7
  - the preamble start bit constant
- Sub-module hplvds_tx_shifter: 8-bit load/shift register with 3-bit bit counter and a last-bit flag. The FSM sits in the top level.

Test Plan:
- Reset then ENABLE_I=1 with SETTLE_CYCLES=64 -> TX_EN_O=1 the next cycle; LINK_UP_O rises exactly 64 cycles later; TX_EI_O stays 1 throughout.
- Single byte 8'hA5 with LAST_I=1 -> DO_O carries 10101010, then BC LSB-first (0,0,1,1,1,1,0,1), then A5 LSB-first, then FD LSB-first. After that TX_EI_O=1 and BUSY_O=1 for 16 cycles.
- Three bytes 01,02,03 back-to-back (LAST_I on 03) -> READY_O pulses exactly 8 cycles apart; 24 contiguous payload bits with no idle between bytes.
- VALID_I dropped after the first byte of a two-byte frame -> UNDERRUN_O pulses once; ABORT_BYTE F7 is sent; GAP follows.
- ENABLE_I deasserted mid-DATA -> next cycle TX_EN_O=0, BUSY_O=0, READY_O=0, state OFF. Re-enabling reruns the full 64-cycle settle.
- VALID_I held high through GAP, and POL_I/BIAS_I/VCM_I changed while the link is up -> the next frame starts only after 16 gap cycles; TX_POL_O, TX_BIAS_O and TX_VCM_O do not change until OFF.
